mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder on the shared MESI snooping bus. It consumes the command/address broadcast the bus drives to all caches, and it returns line data for BUS_RD/BUS_RDX misses after a fixed latency. It absorbs FLUSH write-backs from caches into its backing array. It is instantiated beside the bus arbiter in the top level and is the data source for every cache miss not satisfied by a write-back.

## Interface
Parameters:
- ADDR_W, 8, bus address width
- DATA_W, 8, line data width
- RD_LATENCY, 2, cycles between request capture and response; legal range 1..15

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- bus_cmd_in  in  3  broadcast command: 0 NONE, 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPGR, 4 FLUSH, 5-7 ignored as NONE
- bus_addr_in  in  ADDR_W  broadcast address, valid with bus_cmd_in != NONE
- bus_data_in  in  DATA_W  write-back data, valid with FLUSH
- mem_ready  out  1  responder can capture BUS_RD/BUS_RDX this cycle
- mem_valid  out  1  one-cycle response strobe
- mem_addr_out  out  ADDR_W  address of current response
- mem_data_out  out  DATA_W  response data

## Operation
- Backing array: 2**ADDR_W x DATA_W. It is not cleared by reset, and its contents survive reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - BUS_RD or BUS_RDX: capture the address and read the array into the data register in the same cycle. Load counter = RD_LATENCY-1 and move to WAIT, or move directly to RESP if RD_LATENCY=1.
- WAIT:
  - Decrement the counter each cycle.
  - Move to RESP when the counter is 0.
  - BUS_RD/BUS_RDX arriving here is dropped. The bus must not issue while mem_ready=0.
- RESP:
  - Assert mem_valid, mem_addr_out and mem_data_out for exactly one cycle, then return to IDLE.
  - mem_data_out holds its value after the strobe.
- FLUSH in any state:
  - Write bus_data_in to array[bus_addr_in] at that clock edge.
  - Never stalls, never blocks.
- FLUSH whose address equals a pending captured address, in WAIT or RESP entry cycle: behaviour is set by the macro in Configuration.
- FLUSH to a different address has no effect on the pending request.
- BUS_UPGR is ignored: no array access and no response.
- mem_ready = 1 only in IDLE. It is combinational from state.
- Counter width is 4 bits and never wraps: it is only loaded in IDLE and stops at 0.

## Timing
- Reset values: state IDLE, mem_ready=1, mem_valid=0, mem_addr_out=0, mem_data_out=0, counter 0.
- Reset mid-operation: the pending request is discarded and no mem_valid is issued. Outputs return to reset values asynchronously.
- BUS_RD sampled at edge T in IDLE: mem_ready=0 from T+1, and mem_valid=1 in cycle T+RD_LATENCY (one cycle wide).
- mem_ready returns to 1 the cycle after the mem_valid strobe. The earliest back-to-back request is sampled in that cycle.
- A FLUSH write is visible to a BUS_RD sampled at the following edge. A same-edge FLUSH and BUS_RD to one address cannot occur, because the bus carries one command per cycle.

## Configuration
- MEM_RESP_FWD_EN defined: a same-address FLUSH during a pending read overwrites the data register with bus_data_in. The response timing is unchanged, and the response carries the flushed data.
- MEM_RESP_FWD_EN undefined: a same-address FLUSH restarts the request. The data register is re-read from the array on the cycle after the write, the counter is reloaded to RD_LATENCY-1, and the response is delayed accordingly. mem_ready stays 0 throughout.

## Test plan
- Reset deassert, idle 5 cycles -> mem_ready=1, mem_valid=0, mem_data_out=0.
- FLUSH addr 0x10 data 0xA5, then BUS_RD 0x10 (RD_LATENCY=2) -> mem_valid single cycle two cycles after capture, mem_addr_out=0x10, mem_data_out=0xA5, mem_ready back to 1 next cycle.
- BUS_RDX 0x20 followed immediately by BUS_RD 0x30 while mem_ready=0 -> one response only, for 0x20; no response for 0x30.
- Array 0x40=0x11; BUS_RD 0x40, FLUSH 0x40 data 0x77 one cycle later -> with MEM_RESP_FWD_EN: response 0x77 at the normal cycle; without it: response 0x77 delayed by the restart.
- BUS_RD 0x50 pending, FLUSH 0x51 data 0x33 -> response timing unchanged, data = prior array[0x50]; later BUS_RD 0x51 returns 0x33.
- rst low during WAIT -> no mem_valid, mem_ready=1 after release; array[0x10] still reads 0xA5.

Source files
------------

// File: rtl/mem_responder_if.sv
// Snooping-bus view of the memory responder: command/address/write-back broadcast
// from the bus, plus the ready/response signals returned by memory.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);

    logic [2:0]        bus_cmd_in;
    logic [ADDR_W-1:0] bus_addr_in;
    logic [DATA_W-1:0] bus_data_in;

    logic              mem_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_out;

    // Bus side: drives the broadcast, consumes responses
    modport master (
        output bus_cmd_in,
        output bus_addr_in,
        output bus_data_in,
        input  mem_ready,
        input  mem_valid,
        input  mem_addr_out,
        input  mem_data_out
    );

    // Memory side: consumes the broadcast, returns line data
    modport slave (
        input  bus_cmd_in,
        input  bus_addr_in,
        input  bus_data_in,
        output mem_ready,
        output mem_valid,
        output mem_addr_out,
        output mem_data_out
    );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder on the MESI snooping bus: fixed-latency line reads, FLUSH absorption.
// MEM_RESP_FWD_EN: same-address FLUSH during a pending read forwards data instead of restarting.
module mem_responder #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] CMD_RD    = 3'd1;
    localparam logic [2:0] CMD_RDX   = 3'd2;
    localparam logic [2:0] CMD_FLUSH = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RD_LATENCY - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_reread;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt;
    logic              w_reread_nxt;

    logic              w_is_rd;
    logic              w_is_flush;
    logic              w_hit;
    logic [DATA_W-1:0] w_rd_bus;
    logic [DATA_W-1:0] w_rd_pend;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic              w_cnt_done;

    assign w_is_rd    = (bus.bus_cmd_in == CMD_RD) || (bus.bus_cmd_in == CMD_RDX);
    assign w_is_flush = (bus.bus_cmd_in == CMD_FLUSH);
    assign w_hit      = w_is_flush && (bus.bus_addr_in == r_addr);
    assign w_rd_bus   = r_mem[bus.bus_addr_in];
    assign w_rd_pend  = r_mem[r_addr];
    // Saturating decrement; reaching zero on this edge ends the wait
    assign w_cnt_dec  = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
    assign w_cnt_done = (r_cnt <= CNT_W'(1));

    // Backing array: written by FLUSH in any state, never reset
    always_ff @(posedge clk) begin
        if (w_is_flush) begin
            r_mem[bus.bus_addr_in] <= bus.bus_data_in;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_reread_nxt = 1'b0;

        // Refetch after a restarting FLUSH, now that the write has landed
        if (r_reread) begin
            w_data_nxt = w_rd_pend;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_is_rd) begin
                    w_addr_nxt = bus.bus_addr_in;
                    w_data_nxt = w_rd_bus;
                    w_cnt_nxt  = LOAD_VAL;
                    if (LOAD_VAL == '0) begin
                        w_state_nxt = ST_RESP;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
`ifdef MEM_RESP_FWD_EN
                if (w_hit) begin
                    w_data_nxt = bus.bus_data_in;
                end
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_done) begin
                    w_state_nxt = ST_RESP;
                    w_valid_nxt = 1'b1;
                end
`else
                if (w_hit) begin
                    w_cnt_nxt    = LOAD_VAL;
                    w_reread_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                    if (w_cnt_done) begin
                        w_state_nxt = ST_RESP;
                        w_valid_nxt = 1'b1;
                    end
                end
`endif
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any pending request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_reread <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_reread <= w_reread_nxt;
        end
    end

    assign bus.mem_ready    = (r_state == ST_IDLE);
    assign bus.mem_valid    = r_valid;
    assign bus.mem_addr_out = r_addr;
    assign bus.mem_data_out = r_data;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (RD_LATENCY=2); expectations follow MEM_RESP_FWD_EN.
module tb_mem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [2:0] NONE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] RDX   = 3'd2;
    localparam logic [2:0] UPGR  = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;
    localparam logic [2:0] RSVD  = 3'd5;

    logic clk;
    logic rst;

    int n_checks;
    int n_fails;
    int n_valid;

    mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LATENCY(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one bus command for the next edge, then settle just after it
    task automatic drive(input logic [2:0] cmd, input logic [7:0] addr, input logic [7:0] data);
        bus.bus_cmd_in  = cmd;
        bus.bus_addr_in = addr;
        bus.bus_data_in = data;
        @(posedge clk);
        #1;
    endtask

    task automatic count_idle(input int cycles);
        n_valid = 0;
        for (int i = 0; i < cycles; i++) begin
            drive(NONE, 8'h00, 8'h00);
            if (bus.mem_valid) n_valid++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b0;
        bus.bus_cmd_in  = NONE;
        bus.bus_addr_in = '0;
        bus.bus_data_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset and idle
        count_idle(5);
        check("rst_ready", 32'(bus.mem_ready), 32'd1);
        check("rst_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_data", 32'(bus.mem_data_out), 32'h00);
        check("rst_addr", 32'(bus.mem_addr_out), 32'h00);
        check("rst_idle_strobes", 32'(n_valid), 32'd0);

        // FLUSH then read-back at the normal latency
        drive(FLUSH, 8'h10, 8'hA5);
        drive(RD, 8'h10, 8'h00);
        check("rd_ready_low", 32'(bus.mem_ready), 32'd0);
        check("rd_wait_valid", 32'(bus.mem_valid), 32'd0);
        drive(NONE, 8'h00, 8'h00);
        check("rd_valid", 32'(bus.mem_valid), 32'd1);
        check("rd_addr", 32'(bus.mem_addr_out), 32'h10);
        check("rd_data", 32'(bus.mem_data_out), 32'hA5);
        check("rd_resp_ready", 32'(bus.mem_ready), 32'd0);
        drive(NONE, 8'h00, 8'h00);
        check("rd_valid_drop", 32'(bus.mem_valid), 32'd0);
        check("rd_ready_back", 32'(bus.mem_ready), 32'd1);
        check("rd_data_hold", 32'(bus.mem_data_out), 32'hA5);

        // Request while busy is dropped
        drive(FLUSH, 8'h20, 8'h22);
        drive(FLUSH, 8'h30, 8'h3C);
        drive(RDX, 8'h20, 8'h00);
        drive(RD, 8'h30, 8'h00);
        check("rdx_valid", 32'(bus.mem_valid), 32'd1);
        check("rdx_addr", 32'(bus.mem_addr_out), 32'h20);
        check("rdx_data", 32'(bus.mem_data_out), 32'h22);
        count_idle(6);
        check("drop_strobes", 32'(n_valid), 32'd0);
        check("drop_addr", 32'(bus.mem_addr_out), 32'h20);

        // BUS_UPGR and reserved commands produce nothing
        drive(UPGR, 8'h10, 8'h00);
        check("upgr_ready", 32'(bus.mem_ready), 32'd1);
        drive(RSVD, 8'h10, 8'h00);
        count_idle(4);
        check("upgr_strobes", 32'(n_valid), 32'd0);
        check("upgr_data", 32'(bus.mem_data_out), 32'h22);

        // Same-address FLUSH during a pending read
        drive(FLUSH, 8'h40, 8'h11);
        drive(RD, 8'h40, 8'h00);
        drive(FLUSH, 8'h40, 8'h77);
`ifdef MEM_RESP_FWD_EN
        check("fwd_valid", 32'(bus.mem_valid), 32'd1);
        check("fwd_data", 32'(bus.mem_data_out), 32'h77);
        check("fwd_addr", 32'(bus.mem_addr_out), 32'h40);
        drive(NONE, 8'h00, 8'h00);
        check("fwd_ready_back", 32'(bus.mem_ready), 32'd1);
`else
        check("rst_req_valid_early", 32'(bus.mem_valid), 32'd0);
        check("rst_req_ready", 32'(bus.mem_ready), 32'd0);
        drive(NONE, 8'h00, 8'h00);
        check("rst_req_valid", 32'(bus.mem_valid), 32'd1);
        check("rst_req_data", 32'(bus.mem_data_out), 32'h77);
        check("rst_req_addr", 32'(bus.mem_addr_out), 32'h40);
        drive(NONE, 8'h00, 8'h00);
        check("rst_req_valid_drop", 32'(bus.mem_valid), 32'd0);
        check("rst_req_ready_back", 32'(bus.mem_ready), 32'd1);
`endif

        // Different-address FLUSH leaves the pending read alone
        drive(FLUSH, 8'h50, 8'h5A);
        drive(RD, 8'h50, 8'h00);
        drive(FLUSH, 8'h51, 8'h33);
        check("diff_valid", 32'(bus.mem_valid), 32'd1);
        check("diff_data", 32'(bus.mem_data_out), 32'h5A);
        drive(NONE, 8'h00, 8'h00);
        check("diff_ready_back", 32'(bus.mem_ready), 32'd1);
        drive(RD, 8'h51, 8'h00);
        drive(NONE, 8'h00, 8'h00);
        check("diff_rd51_valid", 32'(bus.mem_valid), 32'd1);
        check("diff_rd51_data", 32'(bus.mem_data_out), 32'h33);
        check("diff_rd51_addr", 32'(bus.mem_addr_out), 32'h51);
        drive(NONE, 8'h00, 8'h00);

        // Reset during WAIT: asynchronous return, no response, array intact
        drive(RD, 8'h10, 8'h00);
        check("mid_wait_ready", 32'(bus.mem_ready), 32'd0);
        bus.bus_cmd_in = NONE;
        rst = 1'b0;
        #2;
        check("mid_rst_ready", 32'(bus.mem_ready), 32'd1);
        check("mid_rst_valid", 32'(bus.mem_valid), 32'd0);
        check("mid_rst_data", 32'(bus.mem_data_out), 32'h00);
        check("mid_rst_addr", 32'(bus.mem_addr_out), 32'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        count_idle(4);
        check("mid_rst_strobes", 32'(n_valid), 32'd0);
        check("mid_rst_ready_after", 32'(bus.mem_ready), 32'd1);
        drive(RD, 8'h10, 8'h00);
        drive(NONE, 8'h00, 8'h00);
        check("persist_valid", 32'(bus.mem_valid), 32'd1);
        check("persist_data", 32'(bus.mem_data_out), 32'hA5);
        drive(NONE, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
